// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, ALUOp encodings and the decoded
// control bundle used by both the hazard control mux and the ID/EX register.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // ALUOp classes produced by the main decoder
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;  // add / load-store address
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  // Decoded control bundle, bubbled to zero by the control mux on a hazard
  typedef struct packed {
    logic [4:0] reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in EX and the source
// indices of the instruction in ID.
// Ports:
//   valid    - EX slot holds a real instruction
//   mem_read - EX instruction is a load
//   rd       - EX destination register index
//   rs1, rs2 - ID-stage source register indices
//   hazard   - load-use hazard (combinational)
module load_use_detect (
  input  logic       valid,
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = valid & mem_read & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Captures decoded control, operands, immediate, PC
// and register indices for EX, with stall (hold), flush (bubble), a valid bit,
// a saturating bubble counter and the load-use hazard flag for the control mux.
// Ports:
//   clk_i, rst_n_i             - clock, async active-low reset
//   stall_i, flush_i, valid_i  - hold / bubble / ID instruction valid
//   *_i control, funct, addr, data inputs  -> registered *_o outputs
//   valid_o                    - EX slot holds a real instruction
//   hazard_o                   - load-use hazard, to control mux Hazard_i
//   bubble_cnt_o               - saturating count of bubbles entering EX
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [4:0]       RegDst_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemToReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [3:0]       funct_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [4:0]       RegDst_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [3:0]       funct_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             valid_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  core_pkg::ctrl_t  ctrl_in;
  core_pkg::ctrl_t  ctrl_q;
  logic [3:0]       funct_q;
  logic [4:0]       rs1_addr_q;
  logic [4:0]       rs2_addr_q;
  logic [XLEN-1:0]  rs1_data_q;
  logic [XLEN-1:0]  rs2_data_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bubble_c;

  assign ctrl_in = '{reg_dst:    RegDst_i,
                     alu_op:     ALUOp_i,
                     alu_src:    ALUSrc_i,
                     reg_write:  RegWrite_i,
                     mem_to_reg: MemToReg_i,
                     mem_read:   MemRead_i,
                     mem_write:  MemWrite_i};

  // Pipeline register: flush beats stall, stall beats load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q     <= '0;
      funct_q    <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      ctrl_q     <= '0;
      funct_q    <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else if (!stall_i) begin
      ctrl_q     <= ctrl_in;
      funct_q    <= funct_i;
      rs1_addr_q <= rs1_addr_i;
      rs2_addr_q <= rs2_addr_i;
      rs1_data_q <= rs1_data_i;
      rs2_data_q <= rs2_data_i;
      imm_q      <= imm_i;
      pc_q       <= pc_i;
      valid_q    <= valid_i;
    end
  end

  // A bubble enters EX on a flush, or on a non-stalled load of an invalid slot
  assign bubble_c = flush_i | (~stall_i & ~valid_i);

  // Saturating bubble counter, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (bubble_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  load_use_detect u_load_use_detect (
    .valid    (valid_q),
    .mem_read (ctrl_q.mem_read),
    .rd       (ctrl_q.reg_dst),
    .rs1      (rs1_addr_i),
    .rs2      (rs2_addr_i),
    .hazard   (hazard_o)
  );

  assign RegDst_o     = ctrl_q.reg_dst;
  assign ALUOp_o      = ctrl_q.alu_op;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign MemToReg_o   = ctrl_q.mem_to_reg;
  assign MemRead_o    = ctrl_q.mem_read;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign funct_o      = funct_q;
  assign rs1_addr_o   = rs1_addr_q;
  assign rs2_addr_o   = rs2_addr_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign pc_o         = pc_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule
